// File: rtl/rgmii_idelay_tap_ctrl_pkg.sv
// Shared types and constants for the RGMII RX IDELAYE2 tap controller.
// Optional build macro: RGMII_IDELAY_TAP_VERIFY_EN (enables readback verification).
package rgmii_idelay_pkg;

    localparam int RGMII_TAP_W  = 5;   // IDELAYE2 CNTVALUE width
    localparam int RGMII_LANES  = 5;   // rx_ctl + rxd[3:0]
    localparam int RGMII_LANE_W = 3;   // request lane field width

    localparam logic [RGMII_LANE_W-1:0] RGMII_LANE_RXCTL = 3'd0;
    localparam logic [RGMII_LANE_W-1:0] RGMII_LANE_BCAST = 3'd5;

    typedef enum logic [2:0] {
        S_CTRL_RST,
        S_WAIT_RDY,
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_VERIFY,
        S_RESP
    } state_e;

    // Lanes 0..4 address one lane, 5 addresses all of them, 6..7 are illegal.
    function automatic logic lane_is_legal(input logic [RGMII_LANE_W-1:0] lane);
        return (lane <= RGMII_LANE_BCAST);
    endfunction

endpackage

// File: rtl/rgmii_idelay_tap_ctrl_if.sv
// Tap-write request / response channel of the IDELAY tap controller.
// Optional build macro: RGMII_IDELAY_TAP_VERIFY_EN (affects resp_err_o meaning only).
interface rgmii_idelay_tap_ctrl_if;
    import rgmii_idelay_pkg::*;

    logic                    tap_v_i;
    logic                    tap_ready_o;
    logic [RGMII_LANE_W-1:0] tap_lane_i;
    logic [RGMII_TAP_W-1:0]  tap_val_i;

    logic                    resp_v_o;
    logic                    resp_yumi_i;
    logic [RGMII_TAP_W-1:0]  resp_tap_o;
    logic                    resp_err_o;

    modport master (
        output tap_v_i, tap_lane_i, tap_val_i, resp_yumi_i,
        input  tap_ready_o, resp_v_o, resp_tap_o, resp_err_o
    );

    modport slave (
        input  tap_v_i, tap_lane_i, tap_val_i, resp_yumi_i,
        output tap_ready_o, resp_v_o, resp_tap_o, resp_err_o
    );

endinterface

// File: rtl/rgmii_idelay_tap_ctrl_rst_seq.sv
// IDELAYCTRL reset sequencer: RST hold timer, RDY synchroniser, RDY timeout.
// Optional build macro: RGMII_IDELAY_TAP_VERIFY_EN (not used in this file).
module rgmii_idelayctrl_rst_seq #(
    parameter int rst_hold_p    = 15,
    parameter int rdy_timeout_p = 1023
) (
    input  logic iodelay_ref_clk_lo,
    input  logic reset_r_i,
    input  logic i_rdy_async,
    input  logic i_wait_en,
    output logic o_rst,
    output logic o_rdy_synced,
    output logic o_timeout
);

    localparam int HOLD_W = (rst_hold_p > 1) ? $clog2(rst_hold_p) : 1;
    localparam int TO_W   = $clog2(rdy_timeout_p + 1);

    logic              r_rst;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_rdy_sync;
    logic [TO_W-1:0]   r_to_cnt;

    // Keep IDELAYCTRL in reset for rst_hold_p cycles after our own reset releases.
    always_ff @(posedge iodelay_ref_clk_lo or posedge reset_r_i) begin
        if (reset_r_i) begin
            r_rst      <= 1'b1;
            r_hold_cnt <= '0;
        end else if (r_rst) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
            if (r_hold_cnt == HOLD_W'(rst_hold_p - 1)) begin
                r_rst <= 1'b0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous RDY from IDELAYCTRL.
    always_ff @(posedge iodelay_ref_clk_lo or posedge reset_r_i) begin
        if (reset_r_i) begin
            r_rdy_sync <= '0;
        end else begin
            r_rdy_sync <= {r_rdy_sync[0], i_rdy_async};
        end
    end

    // Count cycles spent waiting for RDY; saturates at the timeout value.
    always_ff @(posedge iodelay_ref_clk_lo or posedge reset_r_i) begin
        if (reset_r_i) begin
            r_to_cnt <= '0;
        end else if (i_wait_en && !r_rdy_sync[1] && !o_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign o_rst        = r_rst;
    assign o_rdy_synced = r_rdy_sync[1];
    assign o_timeout    = (r_to_cnt == TO_W'(rdy_timeout_p));

endmodule

// File: rtl/rgmii_idelay_tap_ctrl.sv
// Run-time tap programmer for the RGMII RX IDELAYE2 lanes (VAR_LOAD mode).
// Lane 0 = rx_ctl, lanes 1..4 = rxd[0..3]; lane 5 = broadcast.
// Optional build macro: RGMII_IDELAY_TAP_VERIFY_EN compares CNTVALUEOUT of every
// target lane against the written tap and flags mismatches.
module rgmii_idelay_tap_ctrl
    import rgmii_idelay_pkg::*;
#(
    parameter int lanes_p       = RGMII_LANES,
    parameter int init_tap_p    = 0,
    parameter int rst_hold_p    = 15,
    parameter int settle_p      = 3,
    parameter int rdy_timeout_p = 1023
) (
    input  logic                           iodelay_ref_clk_lo,
    input  logic                           reset_r_i,
    input  logic                           idelayctrl_rdy_i,
    output logic                           idelayctrl_rst_o,
    rgmii_idelay_tap_ctrl_if.slave         tap_if,
    output logic [lanes_p-1:0]             idelay_ld_o,
    output logic [RGMII_TAP_W*lanes_p-1:0] idelay_cntvaluein_o,
    input  logic [RGMII_TAP_W*lanes_p-1:0] idelay_cntvalueout_i,
    output logic                           ready_o,
    output logic                           ctrl_err_o
);

    localparam int SETTLE_W = (settle_p > 1) ? $clog2(settle_p) : 1;

    state_e                                  r_state;
    state_e                                  w_state_nxt;
    logic                                    w_rst;
    logic                                    w_rdy_synced;
    logic                                    w_timeout;
    logic                                    w_fire;
    logic                                    w_lane_legal;
    logic [lanes_p-1:0]                      w_req_mask;
    logic [lanes_p-1:0]                      w_tgt_mask;
    logic [RGMII_LANE_W-1:0]                 w_rb_lane;
    logic [RGMII_TAP_W-1:0]                  w_readback;
    logic                                    w_mismatch;

    logic [lanes_p-1:0][RGMII_TAP_W-1:0]     r_cntvaluein;
    logic [RGMII_LANE_W-1:0]                 r_lane;
    logic                                    r_init;
    logic                                    r_ready;
    logic                                    r_ctrl_err;
    logic [RGMII_TAP_W-1:0]                  r_resp_tap;
    logic                                    r_resp_err;
    logic [SETTLE_W-1:0]                     r_settle_cnt;
`ifdef RGMII_IDELAY_TAP_VERIFY_EN
    logic [RGMII_TAP_W-1:0]                  r_val;
`endif

    rgmii_idelayctrl_rst_seq #(
        .rst_hold_p    (rst_hold_p),
        .rdy_timeout_p (rdy_timeout_p)
    ) u_rst_seq (
        .iodelay_ref_clk_lo (iodelay_ref_clk_lo),
        .reset_r_i          (reset_r_i),
        .i_rdy_async        (idelayctrl_rdy_i),
        .i_wait_en          (r_state == S_WAIT_RDY),
        .o_rst              (w_rst),
        .o_rdy_synced       (w_rdy_synced),
        .o_timeout          (w_timeout)
    );

    assign tap_if.resp_v_o    = (r_state == S_RESP);
    assign tap_if.tap_ready_o = (r_state == S_IDLE) && !tap_if.resp_v_o;
    assign tap_if.resp_tap_o  = r_resp_tap;
    assign tap_if.resp_err_o  = r_resp_err;

    assign w_fire       = tap_if.tap_v_i && tap_if.tap_ready_o;
    assign w_lane_legal = lane_is_legal(tap_if.tap_lane_i);
    assign w_rb_lane    = (r_lane == RGMII_LANE_BCAST) ? RGMII_LANE_RXCTL : r_lane;

    // Decode lane masks for the incoming request and the latched target.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_req_mask = '0;
        w_tgt_mask = '0;
        w_readback = '0;
        for (int n = 0; n < lanes_p; n++) begin
            w_req_mask[n] = (tap_if.tap_lane_i == RGMII_LANE_BCAST) || (int'(tap_if.tap_lane_i) == n);
            w_tgt_mask[n] = (r_lane == RGMII_LANE_BCAST) || (int'(r_lane) == n);
            if (int'(w_rb_lane) == n) begin
                w_readback = idelay_cntvalueout_i[RGMII_TAP_W*n +: RGMII_TAP_W];
            end
        end
    end

`ifdef RGMII_IDELAY_TAP_VERIFY_EN
    // Any target lane whose readback differs from the written tap is a mismatch.
    always_comb begin
        w_mismatch = 1'b0;
        for (int n = 0; n < lanes_p; n++) begin
            if (w_tgt_mask[n] && (idelay_cntvalueout_i[RGMII_TAP_W*n +: RGMII_TAP_W] != r_val)) begin
                w_mismatch = 1'b1;
            end
        end
    end
`else
    assign w_mismatch = 1'b0;
`endif

    // State register.
    always_ff @(posedge iodelay_ref_clk_lo or posedge reset_r_i) begin
        if (reset_r_i) begin
            r_state <= S_CTRL_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CTRL_RST: if (!w_rst) w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: if (w_rdy_synced || w_timeout) w_state_nxt = S_INIT;
            S_INIT:     w_state_nxt = S_SETTLE;
            S_IDLE:     if (w_fire) w_state_nxt = w_lane_legal ? S_LOAD : S_RESP;
            S_LOAD:     w_state_nxt = S_SETTLE;
            S_SETTLE:   if (r_settle_cnt == SETTLE_W'(settle_p - 1)) w_state_nxt = S_VERIFY;
            S_VERIFY:   w_state_nxt = r_init ? S_IDLE : S_RESP;
            S_RESP:     if (tap_if.resp_yumi_i) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_CTRL_RST;
        endcase
    end

    // Tap registers, request latch, settle timer and response/status flags.
    always_ff @(posedge iodelay_ref_clk_lo or posedge reset_r_i) begin
        if (reset_r_i) begin
            // NOTE: the CNTVALUEIN bank is reset because it drives the primitives directly; outputs must read 0 in reset.
            r_cntvaluein <= '0;
            r_lane       <= '0;
            r_init       <= 1'b0;
            r_ready      <= 1'b0;
            r_ctrl_err   <= 1'b0;
            r_resp_tap   <= '0;
            r_resp_err   <= 1'b0;
            r_settle_cnt <= '0;
`ifdef RGMII_IDELAY_TAP_VERIFY_EN
            r_val        <= '0;
`endif
        end else begin
            // Initial load targets every lane; a timeout entry is recorded as a controller error.
            if ((r_state == S_WAIT_RDY) && (w_state_nxt == S_INIT)) begin
                for (int n = 0; n < lanes_p; n++) begin
                    r_cntvaluein[n] <= RGMII_TAP_W'(init_tap_p);
                end
                r_lane <= RGMII_LANE_BCAST;
                r_init <= 1'b1;
                if (!w_rdy_synced) r_ctrl_err <= 1'b1;
`ifdef RGMII_IDELAY_TAP_VERIFY_EN
                r_val  <= RGMII_TAP_W'(init_tap_p);
`endif
            end

            // Accepted request: update CNTVALUEIN ahead of the LD cycle, or answer an illegal lane at once.
            if (w_fire) begin
                r_lane <= tap_if.tap_lane_i;
`ifdef RGMII_IDELAY_TAP_VERIFY_EN
                r_val  <= tap_if.tap_val_i;
`endif
                if (w_lane_legal) begin
                    for (int n = 0; n < lanes_p; n++) begin
                        if (w_req_mask[n]) r_cntvaluein[n] <= tap_if.tap_val_i;
                    end
                end else begin
                    r_resp_tap <= '0;
                    r_resp_err <= 1'b1;
                end
            end

            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;

            if (r_state == S_VERIFY) begin
                r_resp_tap <= w_readback;
                r_resp_err <= w_mismatch;
                if (r_init) begin
                    r_init  <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_mismatch) r_ctrl_err <= 1'b1;
                end
            end
        end
    end

    assign idelayctrl_rst_o    = w_rst;
    assign idelay_ld_o         = ((r_state == S_INIT) || (r_state == S_LOAD)) ? w_tgt_mask : '0;
    assign idelay_cntvaluein_o = r_cntvaluein;
    assign ready_o             = r_ready;
    assign ctrl_err_o          = r_ctrl_err;

endmodule

// File: tb/tb_rgmii_idelay_tap_ctrl.sv
// Self-checking bench for rgmii_idelay_tap_ctrl with an IDELAYE2 echo model and
// a response scoreboard. Honours RGMII_IDELAY_TAP_VERIFY_EN when defined.
module tb_rgmii_idelay_tap_ctrl;
    import rgmii_idelay_pkg::*;

`ifdef RGMII_IDELAY_TAP_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        rst_o;
    logic [4:0]  ld;
    logic [24:0] cvi;
    logic [24:0] cvo = '0;
    logic        ready;
    logic        cerr;
    logic [4:0]  stuck_mask = '0;
    logic [24:0] exp_cvi = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] tap;
        logic       err;
        logic [4:0] mask;
    } exp_t;
    exp_t sb[$];

    rgmii_idelay_tap_ctrl_if tap_if ();

    rgmii_idelay_tap_ctrl dut (
        .iodelay_ref_clk_lo   (clk),
        .reset_r_i            (rst),
        .idelayctrl_rdy_i     (rdy),
        .idelayctrl_rst_o     (rst_o),
        .tap_if               (tap_if),
        .idelay_ld_o          (ld),
        .idelay_cntvaluein_o  (cvi),
        .idelay_cntvalueout_i (cvo),
        .ready_o              (ready),
        .ctrl_err_o           (cerr)
    );

    always #5 clk = ~clk;

    // IDELAYE2 model: CNTVALUEOUT follows CNTVALUEIN on LD; a stuck lane always loads 4.
    always @(posedge clk) begin
        for (int n = 0; n < 5; n++) begin
            if (ld[n]) cvo[5*n +: 5] <= stuck_mask[n] ? 5'd4 : cvi[5*n +: 5];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_outs"},
              {rst_o, ld, ready, cerr, tap_if.resp_v_o, tap_if.tap_ready_o, tap_if.resp_err_o, tap_if.resp_tap_o},
              {1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00});
        check({tag, "_cvi"}, cvi, 25'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        tap_if.tap_v_i     = 1'b0;
        tap_if.resp_yumi_i = 1'b0;
        exp_cvi = '0;
        #1;
        check_reset_vals("reset");
        repeat (3) @(negedge clk);
    endtask

    // Release reset and walk through RST hold, RDY (or its timeout) and the initial load.
    task automatic bring_up(input int rdy_delay, input bit rdy_never);
        int hi;
        int c;
        int t;
        int k;
        int extra;
        bit early;
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        do begin
            @(posedge clk);
            #1;
            hi++;
        end while (rst_o && hi < 100);
        check("rst_hold_cycles", hi, 15);
        early = 1'b0;
        if (!rdy_never) begin
            repeat (rdy_delay) @(posedge clk);
            rdy = 1'b1;
        end else begin
            c = 0;
            while (!cerr && c < 2000) begin
                @(posedge clk);
                #1;
                c++;
                if (ld != 0 && !cerr) early = 1'b1;
            end
            check("timeout_window", (c >= 1023 && c <= 1027), 1);
            @(negedge clk);
        end
        t = 0;
        while (ld == 0 && t < 2000) begin
            @(negedge clk);
            t++;
            if (tap_if.tap_ready_o || ready) early = 1'b1;
        end
        check("init_ld_mask", ld, 5'h1f);
        check("init_cvi", cvi, 25'h0);
        k = 0;
        extra = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
            if (ld != 0) extra++;
            if (tap_if.tap_ready_o && !ready) early = 1'b1;
        end
        check("init_ld_to_ready", k, 5);
        check("init_ld_width", extra, 0);
        check("ready_before_init", early, 0);
        check("tap_ready_idle", tap_if.tap_ready_o, 1);
        check("ctrl_err_after_init", cerr, rdy_never);
    endtask

    // Drive one request, collect LD activity, then compare the response to the scoreboard.
    task automatic request(input logic [2:0] lane, input logic [4:0] val, input int hold);
        exp_t e;
        exp_t got;
        logic       legal;
        logic [2:0] sel;
        logic [4:0] ld_or;
        int         ld_cyc;
        int         t;
        legal  = (lane <= 3'd5);
        e.mask = (lane == 3'd5) ? 5'h1f : (lane < 3'd5) ? 5'(1 << lane) : 5'h00;
        sel    = (lane == 3'd5) ? 3'd0 : lane;
        e.tap  = legal ? (stuck_mask[sel] ? 5'd4 : val) : 5'd0;
        e.err  = !legal || (VERIFY_EN && ((e.mask & stuck_mask) != 0) && (val != 5'd4));
        sb.push_back(e);
        for (int n = 0; n < 5; n++) begin
            if (e.mask[n]) exp_cvi[5*n +: 5] = val;
        end

        @(negedge clk);
        tap_if.tap_v_i    = 1'b1;
        tap_if.tap_lane_i = lane;
        tap_if.tap_val_i  = val;
        t = 0;
        while (!tap_if.tap_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!tap_if.tap_ready_o) begin
            check("handshake_timeout", 0, 1);
            tap_if.tap_v_i = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        tap_if.tap_v_i = 1'b0;

        ld_or  = '0;
        ld_cyc = 0;
        for (t = 0; t < 30; t++) begin
            ld_or |= ld;
            if (ld != 0) ld_cyc++;
            if (tap_if.resp_v_o) break;
            @(negedge clk);
        end
        got = sb.pop_front();
        if (!tap_if.resp_v_o) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("ld_mask", ld_or, got.mask);
        check("ld_cycles", ld_cyc, (got.mask != 0) ? 1 : 0);
        check("resp_tap", tap_if.resp_tap_o, got.tap);
        check("resp_err", tap_if.resp_err_o, got.err);
        check("cntvaluein", cvi, exp_cvi);
        check("tap_ready_in_resp", tap_if.tap_ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable",
                  {tap_if.resp_v_o, tap_if.resp_tap_o, tap_if.resp_err_o, tap_if.tap_ready_o, ld},
                  {1'b1, got.tap, got.err, 1'b0, 5'h00});
        end
        tap_if.resp_yumi_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tap_if.resp_yumi_i = 1'b0;
        check("resp_v_after_yumi", tap_if.resp_v_o, 0);
    endtask

    // Reset asserted in the first settle cycle of a request must drop everything at once.
    task automatic reset_mid_settle();
        int t;
        @(negedge clk);
        tap_if.tap_v_i    = 1'b1;
        tap_if.tap_lane_i = 3'd1;
        tap_if.tap_val_i  = 5'd12;
        t = 0;
        while (!tap_if.tap_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        tap_if.tap_v_i = 1'b0;
        check("mid_ld", ld, 5'b00010);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        exp_cvi = '0;
        #1;
        check_reset_vals("mid_settle_reset");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tap_if.tap_v_i     = 1'b0;
        tap_if.tap_lane_i  = '0;
        tap_if.tap_val_i   = '0;
        tap_if.resp_yumi_i = 1'b0;

        apply_reset();
        bring_up(5, 1'b0);

        request(3'd2, 5'd17, 0);
        request(3'd0, 5'd31, 0);
        request(3'd4, 5'd0, 0);
        stuck_mask = 5'b01000;
        request(3'd5, 5'd9, 0);
        stuck_mask = '0;
        request(3'd7, 5'd21, 10);
        request(3'd6, 5'd3, 0);

        reset_mid_settle();
        bring_up(2, 1'b0);
        request(3'd3, 5'd5, 0);

        apply_reset();
        bring_up(0, 1'b1);
        request(3'd1, 5'd30, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
